// File: rtl/mode_counter_pkg.sv
// Shared mode encoding for the parametrised mode counter and its next-state logic.
package mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DN1  = 2'd1,
        MODE_DNS  = 2'd2,
        MODE_LOAD = 2'd3
    } mode_e;

endpackage

// File: rtl/mode_counter_next.sv
// Combinational next-count and wrap/clamp detect for mode_counter_param.
// MODE_COUNTER_SAT_EN selects saturating arithmetic instead of modulo wrap.
module mode_counter_next
    import mode_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [1:0]       modo_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] next_q_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    mode_e mode;
    assign mode = mode_e'(modo_i);

    always_comb begin
        next_q_o = q_i;
        wrap_o   = 1'b0;
        unique case (mode)
            MODE_UP: begin
                wrap_o = (q_i == ALL_ONES);
`ifdef MODE_COUNTER_SAT_EN
                next_q_o = wrap_o ? ALL_ONES : q_i + 1'b1;
`else
                next_q_o = q_i + 1'b1;
`endif
            end
            MODE_DN1: begin
                wrap_o = (q_i == '0);
`ifdef MODE_COUNTER_SAT_EN
                next_q_o = wrap_o ? '0 : q_i - 1'b1;
`else
                next_q_o = q_i - 1'b1;
`endif
            end
            MODE_DNS: begin
                wrap_o = (q_i < STEP_W);
`ifdef MODE_COUNTER_SAT_EN
                next_q_o = wrap_o ? '0 : q_i - STEP_W;
`else
                next_q_o = q_i - STEP_W;
`endif
            end
            MODE_LOAD: begin
                next_q_o = d_i;
            end
        endcase
    end

endmodule

// File: rtl/mode_counter_param.sv
// WIDTH-bit four-mode counter with cascade enable and lookahead ripple-carry output.
// Optional saturating arithmetic via MODE_COUNTER_SAT_EN (see mode_counter_next).
module mode_counter_param
    import mode_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ci,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("mode_counter_param: WIDTH must be in 2..32");
    end
    if (STEP < 1 || longint'(STEP) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_step
        $error("mode_counter_param: STEP must be in 1..2^WIDTH-1");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic             active;

    mode_counter_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .q_i      (cnt_q),
        .modo_i   (modo),
        .d_i      (d),
        .next_q_o (cnt_d),
        .wrap_o   (wrap)
    );

    assign active = enable && ci;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (active) begin
            cnt_q <= cnt_d;
        end
    end

    // Lookahead: wrap is already zero in load mode, so rco never fires there.
    assign rco = active && wrap;
    assign q   = cnt_q;

endmodule

// File: tb/tb_mode_counter_param.sv
// Directed bench for mode_counter_param (WIDTH=4, STEP=3) plus a two-stage chain.
// Build with MODE_COUNTER_SAT_EN defined to exercise the saturating variant.
module tb_mode_counter_param;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       ci;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;

    logic       ch_en;
    logic [3:0] ch_q0, ch_q1;
    logic       ch_rco0, ch_rco1;

    int passed = 0;
    int total  = 0;

    mode_counter_param #(.WIDTH(4), .STEP(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .ci     (ci),
        .modo   (modo),
        .d      (d),
        .q      (q),
        .rco    (rco)
    );

    mode_counter_param #(.WIDTH(4), .STEP(3)) u_lo (
        .clk    (clk),
        .rst    (rst),
        .enable (ch_en),
        .ci     (1'b1),
        .modo   (2'd0),
        .d      (4'd0),
        .q      (ch_q0),
        .rco    (ch_rco0)
    );

    mode_counter_param #(.WIDTH(4), .STEP(3)) u_hi (
        .clk    (clk),
        .rst    (rst),
        .enable (ch_en),
        .ci     (ch_rco0),
        .modo   (2'd0),
        .d      (4'd0),
        .q      (ch_q1),
        .rco    (ch_rco1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Inputs change 2 time units after the rising edge, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        ci     = 1'b1;
        modo   = 2'd1;
        d      = 4'd0;
        ch_en  = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("reset_q", q, 0);
        chk("reset_rco_dn1_at_0", rco, 1);
        tick();
        chk("edge_during_reset_q", q, 0);
        rst = 1'b1;

`ifdef MODE_COUNTER_SAT_EN
        modo = 2'd3; d = 4'd2;
        tick();
        chk("sat_load2_q", q, 2);
        modo = 2'd2; #1;
        chk("sat_dns_rco_q2", rco, 1);
        tick();
        chk("sat_dns_q1", q, 0);
        chk("sat_dns_rco_q0", rco, 1);
        tick();
        chk("sat_dns_q2", q, 0);
        modo = 2'd3; d = 4'd15;
        tick();
        chk("sat_load15_q", q, 15);
        modo = 2'd0; #1;
        chk("sat_up_rco_a", rco, 1);
        tick();
        chk("sat_up_q1", q, 15);
        chk("sat_up_rco_b", rco, 1);
        tick();
        chk("sat_up_q2", q, 15);
        chk("sat_up_rco_c", rco, 1);
        modo = 2'd1; d = 4'd0;
        modo = 2'd3;
        tick();
        modo = 2'd1; #1;
        chk("sat_dn1_rco_at_0", rco, 1);
        tick();
        chk("sat_dn1_hold_0", q, 0);
`else
        modo = 2'd3; d = 4'd13;
        tick();
        chk("load13_q", q, 13);
        chk("load_rco", rco, 0);
        modo = 2'd0; #1;
        chk("up_rco_q13", rco, 0);
        tick();
        chk("up_q14", q, 14);
        chk("up_rco_q14", rco, 0);
        tick();
        chk("up_q15", q, 15);
        chk("up_rco_q15", rco, 1);
        tick();
        chk("up_wrap_q0", q, 0);
        chk("up_rco_q0", rco, 0);
        tick();
        chk("up_q1", q, 1);
        chk("up_rco_q1", rco, 0);

        modo = 2'd3; d = 4'd4;
        tick();
        chk("load4_q", q, 4);
        modo = 2'd2; #1;
        chk("dns_rco_q4", rco, 0);
        tick();
        chk("dns_q1", q, 1);
        chk("dns_rco_q1", rco, 1);
        tick();
        chk("dns_wrap_q14", q, 14);
        chk("dns_rco_q14", rco, 0);
        tick();
        chk("dns_q11", q, 11);

        modo = 2'd3; d = 4'd0;
        tick();
        modo = 2'd1; #1;
        chk("dn1_rco_q0", rco, 1);
        tick();
        chk("dn1_wrap_q15", q, 15);
        chk("dn1_rco_q15", rco, 0);
        tick();
        chk("dn1_q14", q, 14);

        modo = 2'd3; d = 4'd15; #1;
        chk("load_mode_rco_never", rco, 0);
        tick();
        chk("load15_q", q, 15);
        chk("load15_rco_still_load", rco, 0);
        modo = 2'd0; #1;
        chk("after_load15_up_rco", rco, 1);

        ch_en = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("chain16_lo", ch_q0, 0);
        chk("chain16_hi", ch_q1, 1);
        for (int i = 0; i < 239; i++) tick();
        chk("chain255_lo", ch_q0, 15);
        chk("chain255_hi", ch_q1, 15);
        chk("chain255_hi_rco", ch_rco1, 1);
        tick();
        chk("chain256_lo", ch_q0, 0);
        chk("chain256_hi", ch_q1, 0);
        ch_en = 1'b0;
`endif

        modo = 2'd3; d = 4'd5;
        tick();
        chk("load5_q", q, 5);
        modo = 2'd0; enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_en0_q", q, 5);
            chk("hold_en0_rco", rco, 0);
        end
        modo = 2'd3; d = 4'd9;
        tick();
        chk("hold_ignores_d", q, 5);
        modo = 2'd0; enable = 1'b1; ci = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ci0_q", q, 5);
            chk("hold_ci0_rco", rco, 0);
        end
        ci = 1'b1;
        tick();
        chk("resume_q6", q, 6);

        modo = 2'd3; d = 4'd9;
        tick();
        chk("load9_q", q, 9);
        modo = 2'd0;
        #3 rst = 1'b0;
        #1;
        chk("async_reset_q", q, 0);
        tick();
        chk("coincident_edge_q", q, 0);
        rst = 1'b1;
        tick();
        chk("first_edge_after_release", q, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mode_counter_param.md
# mode_counter_param

Parametrised successor of the team's 4-bit mode counter: a WIDTH-bit synchronous counter with four modes (up by 1, down by 1, down by STEP, parallel load). It adds a cascade input and a lookahead ripple-carry output, so several instances can be chained into wider counters. It sits in the Tarea-series datapath next to the existing counter and is driven by the same style of directed tester.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..32.
- STEP, 3: decrement used in mode 2; legal range 1..2^WIDTH-1; elaborate-time error outside that range.
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-low.
- enable  input  1  local count enable; low means hold.
- ci  input  1  cascade enable from the previous stage's rco; tie to 1 on the first stage.
- modo  input  2  mode select: 0 up+1, 1 down-1, 2 down-STEP, 3 load d.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  registered count.
- rco  output  1  combinational lookahead: the next active edge wraps (or clamps).

## Operation
- An edge is active when enable && ci. On an active edge:
  - modo=0: q <= q+1.
  - modo=1: q <= q-1.
  - modo=2: q <= q-STEP.
  - modo=3: q <= d.
- Arithmetic is modulo 2^WIDTH by default.
  - Up from all-ones gives 0.
  - Down-STEP with q<STEP gives q+2^WIDTH-STEP. For example, WIDTH=4, STEP=3, q=1 gives 14.
- Inactive edge: q holds and d is ignored.
- rco = enable && ci && ((modo==0 && q==all-ones) || (modo==1 && q==0) || (modo==2 && q<STEP)).
  - rco is never asserted in mode 3.
- Chaining: stage k+1 ci = stage k rco. Higher stages then step exactly on the edge where the lower stage wraps.
  - Chaining is only meaningful for modes 0 and 1 with all stages in the same mode.
- Mode, d or enable changes take effect on the next rising edge. There is no internal mode register and no settling cycle.

## Timing
- Reset: rst low clears q to 0 immediately, independent of clk. rst dominates enable, ci and modo.
- Release: the first edge with rst high may count.
- rco after reset follows its combinational equation. With q=0, modo=1 and enable=ci=1, rco is 1 during reset.
- Latency: q reflects the mode action one edge after sampling.
- rco is valid in the same cycle as the q/modo/enable it is computed from, with zero latency.
- Reset mid-count: q goes to 0 asynchronously. An edge coincident with rst low has no effect.
- Load of all-ones followed by mode 0: rco rises in the cycle after the load edge.

## Configuration
- MODE_COUNTER_SAT_EN undefined: modulo wrap as described above.
- MODE_COUNTER_SAT_EN defined: saturating arithmetic.
  - Mode 0 at all-ones holds all-ones.
  - Mode 1 at 0 holds 0.
  - Mode 2 with q<STEP gives 0.
  - rco uses the same equation and indicates "next active edge clamps". Load is unaffected.

## Structure
- Package mode_counter_pkg holds:
  - Mode constants MODE_UP=2'd0, MODE_DN1=2'd1, MODE_DNS=2'd2, MODE_LOAD=2'd3.
  - The shared 2-bit mode typedef.
- Sub-module mode_counter_next: purely combinational. It takes q, modo, d and STEP and returns next_q and wrap. The top level holds only the register and the enable gating.

## Test plan
All scenarios use WIDTH=4, STEP=3 unless noted.
- Up wrap: load 13, modo=0, enable=ci=1 -> q 14, 15, 0, 1. rco=1 only while q=15.
- Down-STEP wrap: load 4, modo=2 -> q 1, 14, 11. rco=1 only while q=1 or 0..2.
- Hold and cascade: modo=0, enable toggled 0 for 5 cycles, then ci=0 for 3 cycles -> q frozen both times, rco=0.
- Async reset mid-count: pull rst low between edges at q=9 -> q=0 before the next edge. No count on the coincident edge.
- Two-stage chain, WIDTH=4 each, modo=0 from 0: after 16 edges, upper=1 and lower=0. After 255 edges both stages are 15 and the upper rco=1.
- MODE_COUNTER_SAT_EN defined: load 2, modo=2 -> q 0, 0. Load 15, modo=0 -> q 15, 15, with rco=1 throughout.
